rom_port_arb: RTL

Port arbiter and load sequencer in front of the program ROM. Shares the ROM's single read port between instruction fetch (IF) and load/store (LS), routes LS and loader writes to the write port, and sequences a program-load session that quiesces reads while a loader image is written. Sits between the core's IF/LSU bus ports and the ROM instance.

---
 rtl/rom_port_arb_pkg.sv | 17 +
 rtl/rom_port_arb_arb2_rr.sv | 51 +++++
 rtl/rom_port_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rom_port_arb_pkg.sv
// Shared types for the ROM port arbiter: session FSM states and read-owner tags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_port_arb_pkg;

  // Session states: normal arbitration, one-cycle read drain, loader owns write port
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } arb_state_t;

  // Owner tag registered with each read grant, steers the response
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/rom_port_arb_arb2_rr.sv
// Two-requester read arbiter; req0 = IF, req1 = LS. Round-robin with ROM_ARB_RR_EN, else LS wins.
// Latency: combinational grant; pointer (RR build only) updates on the clock after a contested grant.
// Backpressure: grants only while en is high; a losing requester simply sees no grant.
module rom_port_arb_arb2_rr (
`ifdef ROM_ARB_RR_EN
  input  logic clk,
  input  logic rstn,
`endif
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ROM_ARB_RR_EN
  // ptr = 0 favours req0 (IF), ptr = 1 favours req1 (LS)
  logic ptr;

  // Grant: pointer decides only when both request
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer moves to the loser after every contested grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= 1'b0;
    end else if (en && req0 && req1) begin
      ptr <= ~ptr;
    end
  end
`else
  // Fixed priority: LS over IF
  always_comb begin
    gnt1 = en & req1;
    gnt0 = en & req0 & ~req1;
  end
`endif

endmodule

// File: rtl/rom_port_arb.sv
// ROM port arbiter/load sequencer: shares ROM read port between IF and LS, steers LS/loader writes. Option macro: ROM_ARB_RR_EN.
// Latency: read grant combinational, response one cycle after grant; writes go to the ROM in the accept cycle.
// Backpressure: readies low for losing reads and in DRAIN/LOAD; responses are pulses with no backpressure.
module rom_port_arb
  import rom_port_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic          ls_req_we,
  input  logic [AW-1:0] ls_req_addr,
  input  logic [DW-1:0] ls_req_wdata,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rsp_data,
  input  logic          ld_active,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ready,
  output logic          rom_wen,
  output logic [AW-1:0] rom_w_addr,
  output logic [DW-1:0] rom_w_data,
  output logic          rom_ren,
  output logic [AW-1:0] rom_r_addr,
  input  logic [DW-1:0] rom_r_data
);

  // Byte-offset bits inside one ROM word; ignored when matching write/read words
  localparam int WB = $clog2(DW / 8);

  arb_state_t    state, state_nxt;
  logic          run;
  logic          gnt_if, gnt_ls;
  logic          byp;
  logic          rd_pend, rd_own, byp_q;
  logic [DW-1:0] byp_dat;
  logic [DW-1:0] rsp_dat;
  logic [DW-1:0] if_dat_q, ls_dat_q;

  assign run = (state == ST_RUN);

  // Session state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state: DRAIN is a single cycle because read latency is one
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (ld_active) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_LOAD;
      ST_LOAD:  if (!ld_active) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  rom_port_arb_arb2_rr u_arb (
`ifdef ROM_ARB_RR_EN
    .clk  (clk),
    .rstn (rstn),
`endif
    .en   (run),
    .req0 (if_req_valid),
    .req1 (ls_req_valid & ~ls_req_we),
    .gnt0 (gnt_if),
    .gnt1 (gnt_ls)
  );

  // Handshakes and ROM port drive; LS writes never contend with reads
  always_comb begin
    if_req_ready = gnt_if;
    ls_req_ready = gnt_ls | (run & ls_req_valid & ls_req_we);
    ld_ready     = (state == ST_LOAD);
    rom_ren      = gnt_if | gnt_ls;
    rom_r_addr   = gnt_ls ? ls_req_addr : if_req_addr;
    rom_wen      = 1'b0;
    rom_w_addr   = ls_req_addr;
    rom_w_data   = ls_req_wdata;
    if (run) begin
      rom_wen = ls_req_valid & ls_req_we;
    end else if (state == ST_LOAD) begin
      rom_wen    = ld_wen;
      rom_w_addr = ld_addr;
      rom_w_data = ld_wdata;
    end
    byp = rom_wen & rom_ren & (rom_w_addr[AW-1:WB] == rom_r_addr[AW-1:WB]);
  end

  // Capture owner and same-word write bypass at grant time
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend <= 1'b0;
      rd_own  <= OWN_IF;
      byp_q   <= 1'b0;
      byp_dat <= '0;
    end else begin
      rd_pend <= rom_ren;
      if (rom_ren) begin
        rd_own  <= gnt_ls ? OWN_LS : OWN_IF;
        byp_q   <= byp;
        byp_dat <= rom_w_data;
      end
    end
  end

  // Response steering: new write data wins over the stale ROM word
  always_comb begin
    rsp_dat      = byp_q ? byp_dat : rom_r_data;
    if_rsp_valid = rd_pend & (rd_own == OWN_IF);
    ls_rsp_valid = rd_pend & (rd_own == OWN_LS);
    if_rsp_data  = if_rsp_valid ? rsp_dat : if_dat_q;
    ls_rsp_data  = ls_rsp_valid ? rsp_dat : ls_dat_q;
  end

  // Hold last delivered data per port so a non-owner output stays stable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_dat_q <= '0;
      ls_dat_q <= '0;
    end else begin
      if (if_rsp_valid) if_dat_q <= rsp_dat;
      if (ls_rsp_valid) ls_dat_q <= rsp_dat;
    end
  end

endmodule
